// File: rtl/instr_decode_ctrl.sv
// Fetch/decode/sequencing controller feeding the processor datapath.
// Optional feature: define DECODER_JUMP_EN to make opcode 5'b11101 a PC-absolute jump (otherwise it is a NOP).
module instr_decode_ctrl #(
    parameter int                  PC_WIDTH = 16,
    parameter logic [PC_WIDTH-1:0] RESET_PC = {PC_WIDTH{1'b0}}
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                run,
    output logic [PC_WIDTH-1:0] instr_addr,
    output logic                instr_req,
    input  logic [31:0]         instr_data,
    input  logic                instr_valid,
    input  logic                alu_done,
    input  logic                reg_done,
    output logic [4:0]          opcode,
    output logic [1:0]          read_write,
    output logic [2:0]          control,
    output logic [15:0]         imm_val,
    output logic [2:0]          read_addr_0,
    output logic [2:0]          read_addr_1,
    output logic [2:0]          write_addr_0,
    output logic [2:0]          write_addr_1,
    output logic [PC_WIDTH-1:0] pc,
    output logic                halted,
    output logic                busy
);

    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_FETCH  = 3'd1,
        S_DECODE = 3'd2,
        S_EXEC   = 3'd3,
        S_WB     = 3'd4,
        S_HALT   = 3'd5
    } state_t;

    localparam logic [4:0] OP_LOADI = 5'b11111;
    localparam logic [4:0] OP_IN    = 5'b11100;
    localparam logic [4:0] OP_JMP   = 5'b11101;
    localparam logic [4:0] OP_HALT  = 5'b11110;
    localparam logic [4:0] OP_DUAL0 = 5'b00011;
    localparam logic [4:0] OP_DUAL1 = 5'b00100;

    state_t              state_q, state_d;
    logic [PC_WIDTH-1:0] pc_q, pc_d;
    logic [PC_WIDTH-1:0] pc_inc_s;
    logic                instr_req_q, instr_req_d;
    logic [31:0]         ir_q, ir_d;
    logic [4:0]          opcode_q, opcode_d;
    logic [1:0]          rw_dec_q, rw_dec_d;
    logic [1:0]          read_write_q, read_write_d;
    logic [2:0]          control_q, control_d;
    logic [15:0]         imm_q, imm_d;
    logic [2:0]          ra0_q, ra0_d;
    logic [2:0]          ra1_q, ra1_d;
    logic [2:0]          wa0_q, wa0_d;
    logic [2:0]          wa1_q, wa1_d;
    logic                halted_q, halted_d;
    logic                busy_q, busy_d;

    // PC wraps naturally at 2^PC_WIDTH.
    assign pc_inc_s = pc_q + {{(PC_WIDTH-1){1'b0}}, 1'b1};

    // Next-state and next-output computation for the sequencing FSM.
    always_comb begin
        state_d      = state_q;
        pc_d         = pc_q;
        instr_req_d  = instr_req_q;
        ir_d         = ir_q;
        opcode_d     = opcode_q;
        rw_dec_d     = rw_dec_q;
        read_write_d = read_write_q;
        control_d    = control_q;
        imm_d        = imm_q;
        ra0_d        = ra0_q;
        ra1_d        = ra1_q;
        wa0_d        = wa0_q;
        wa1_d        = wa1_q;

        case (state_q)
            S_IDLE: begin
                read_write_d = 2'b00;
                if (run) begin
                    state_d     = S_FETCH;
                    instr_req_d = 1'b1;
                end else begin
                    instr_req_d = 1'b0;
                end
            end

            S_FETCH: begin
                read_write_d = 2'b00;
                if (instr_valid) begin
                    ir_d        = instr_data;
                    instr_req_d = 1'b0;
                    state_d     = S_DECODE;
                end else begin
                    instr_req_d = 1'b1;
                end
            end

            S_DECODE: begin
                // R-type field layout is the default; I-type ops override below.
                opcode_d     = ir_q[31:27];
                wa0_d        = ir_q[26:24];
                wa1_d        = ir_q[23:21];
                ra0_d        = ir_q[20:18];
                ra1_d        = ir_q[17:15];
                control_d    = 3'b000;
                imm_d        = 16'h0000;
                rw_dec_d     = 2'b01;
                read_write_d = 2'b00;
                state_d      = S_EXEC;
                case (ir_q[31:27])
                    OP_LOADI: begin
                        control_d    = 3'b011;
                        imm_d        = ir_q[15:0];
                        wa1_d        = 3'b000;
                        ra0_d        = 3'b000;
                        ra1_d        = 3'b000;
                        read_write_d = 2'b01;
                        state_d      = S_WB;
                    end
                    OP_IN: begin
                        control_d    = 3'b001;
                        wa1_d        = 3'b000;
                        ra0_d        = 3'b000;
                        ra1_d        = 3'b000;
                        read_write_d = 2'b01;
                        state_d      = S_WB;
                    end
                    OP_JMP: begin
                        rw_dec_d    = 2'b00;
                        imm_d       = ir_q[15:0];
                        instr_req_d = 1'b1;
                        state_d     = S_FETCH;
`ifdef DECODER_JUMP_EN
                        pc_d        = ir_q[PC_WIDTH-1:0];
`else
                        pc_d        = pc_inc_s;
`endif
                    end
                    OP_HALT: begin
                        rw_dec_d = 2'b00;
                        state_d  = S_HALT;
                    end
                    OP_DUAL0, OP_DUAL1: begin
                        rw_dec_d = 2'b11;
                    end
                    default: begin
                        rw_dec_d = 2'b01;
                    end
                endcase
            end

            S_EXEC: begin
                if (alu_done) begin
                    read_write_d = rw_dec_q;
                    state_d      = S_WB;
                end else begin
                    read_write_d = 2'b00;
                end
            end

            S_WB: begin
                if (reg_done) begin
                    read_write_d = 2'b00;
                    pc_d         = pc_inc_s;
                    if (run) begin
                        state_d     = S_FETCH;
                        instr_req_d = 1'b1;
                    end else begin
                        state_d     = S_IDLE;
                        instr_req_d = 1'b0;
                    end
                end else begin
                    read_write_d = read_write_q;
                end
            end

            S_HALT: begin
                read_write_d = 2'b00;
                instr_req_d  = 1'b0;
            end

            default: begin
                state_d      = S_IDLE;
                read_write_d = 2'b00;
                instr_req_d  = 1'b0;
            end
        endcase

        busy_d   = (state_d != S_IDLE) && (state_d != S_HALT);
        halted_d = (state_d == S_HALT);
    end

    // State and registered-output flops; reset aborts any write in flight.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q      <= S_IDLE;
            pc_q         <= RESET_PC;
            instr_req_q  <= 1'b0;
            ir_q         <= 32'h0000_0000;
            opcode_q     <= 5'b00000;
            rw_dec_q     <= 2'b00;
            read_write_q <= 2'b00;
            control_q    <= 3'b000;
            imm_q        <= 16'h0000;
            ra0_q        <= 3'b000;
            ra1_q        <= 3'b000;
            wa0_q        <= 3'b000;
            wa1_q        <= 3'b000;
            halted_q     <= 1'b0;
            busy_q       <= 1'b0;
        end else begin
            state_q      <= state_d;
            pc_q         <= pc_d;
            instr_req_q  <= instr_req_d;
            ir_q         <= ir_d;
            opcode_q     <= opcode_d;
            rw_dec_q     <= rw_dec_d;
            read_write_q <= read_write_d;
            control_q    <= control_d;
            imm_q        <= imm_d;
            ra0_q        <= ra0_d;
            ra1_q        <= ra1_d;
            wa0_q        <= wa0_d;
            wa1_q        <= wa1_d;
            halted_q     <= halted_d;
            busy_q       <= busy_d;
        end
    end

    assign instr_addr   = pc_q;
    assign pc           = pc_q;
    assign instr_req    = instr_req_q;
    assign opcode       = opcode_q;
    assign read_write   = read_write_q;
    assign control      = control_q;
    assign imm_val      = imm_q;
    assign read_addr_0  = ra0_q;
    assign read_addr_1  = ra1_q;
    assign write_addr_0 = wa0_q;
    assign write_addr_1 = wa1_q;
    assign halted       = halted_q;
    assign busy         = busy_q;

endmodule

// File: tb/tb_instr_decode_ctrl.sv
// Scoreboard bench for instr_decode_ctrl: stimulus pushes expected fetches/writes, a monitor pops and compares.
module tb_instr_decode_ctrl;

    logic        clk = 1'b0;
    logic        rst, run, run_b;
    logic        alu_done, reg_done;
    logic        instr_valid, instr_valid_b;
    logic [31:0] instr_data, instr_data_b;

    logic [15:0] instr_addr, pc, instr_addr_b, pc_b;
    logic        instr_req, halted, busy, instr_req_b, halted_b, busy_b;
    logic [4:0]  opcode, opcode_b;
    logic [1:0]  read_write, read_write_b;
    logic [2:0]  control, control_b;
    logic [15:0] imm_val, imm_val_b;
    logic [2:0]  ra0, ra1, wa0, wa1, ra0_b, ra1_b, wa0_b, wa1_b;

    always #5 clk = ~clk;

    instr_decode_ctrl #(.PC_WIDTH(16), .RESET_PC(16'h0010)) dut (
        .clk(clk), .rst(rst), .run(run),
        .instr_addr(instr_addr), .instr_req(instr_req),
        .instr_data(instr_data), .instr_valid(instr_valid),
        .alu_done(alu_done), .reg_done(reg_done),
        .opcode(opcode), .read_write(read_write), .control(control), .imm_val(imm_val),
        .read_addr_0(ra0), .read_addr_1(ra1), .write_addr_0(wa0), .write_addr_1(wa1),
        .pc(pc), .halted(halted), .busy(busy)
    );

    instr_decode_ctrl #(.PC_WIDTH(16), .RESET_PC(16'hFFFF)) dut_wrap (
        .clk(clk), .rst(rst), .run(run_b),
        .instr_addr(instr_addr_b), .instr_req(instr_req_b),
        .instr_data(instr_data_b), .instr_valid(instr_valid_b),
        .alu_done(alu_done), .reg_done(reg_done),
        .opcode(opcode_b), .read_write(read_write_b), .control(control_b), .imm_val(imm_val_b),
        .read_addr_0(ra0_b), .read_addr_1(ra1_b), .write_addr_0(wa0_b), .write_addr_1(wa1_b),
        .pc(pc_b), .halted(halted_b), .busy(busy_b)
    );

    typedef struct {
        logic [1:0]  rw;
        logic [4:0]  op;
        logic [2:0]  ctrl;
        logic [15:0] imm;
        logic [2:0]  wa0, wa1, ra0, ra1;
        bit          chk_r;
        int          len;
        int          dly;
        logic [15:0] pc_after;
    } wr_t;

    wr_t         wr_q[$];
    logic [15:0] fetch_q[$];
    logic [31:0] mem [logic [15:0]];
    int          n_checks = 0;
    int          n_pass   = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", name, act, exp);
    endtask

    function automatic logic [31:0] rd(input logic [15:0] a);
        return mem.exists(a) ? mem[a] : 32'hF000_0000;
    endfunction

    function automatic logic [31:0] r_type(input logic [4:0] op, input logic [2:0] w0, input logic [2:0] w1,
                                           input logic [2:0] r0, input logic [2:0] r1);
        return {op, w0, w1, r0, r1, 15'h0000};
    endfunction

    function automatic wr_t mk_wr(input logic [1:0] rw, input logic [4:0] op, input logic [2:0] ctrl,
                                  input logic [15:0] imm, input logic [2:0] w0, input logic [2:0] w1,
                                  input logic [2:0] r0, input logic [2:0] r1, input bit chk_r,
                                  input int len, input int dly, input logic [15:0] pc_after);
        wr_t w;
        w.rw = rw; w.op = op; w.ctrl = ctrl; w.imm = imm;
        w.wa0 = w0; w.wa1 = w1; w.ra0 = r0; w.ra1 = r1; w.chk_r = chk_r;
        w.len = len; w.dly = dly; w.pc_after = pc_after;
        return w;
    endfunction

    // Zero-wait instruction memory for both instances.
    initial begin
        instr_valid = 1'b0; instr_valid_b = 1'b0;
        instr_data = 32'h0; instr_data_b = 32'h0;
        forever begin
            @(posedge clk);
            #1;
            instr_valid   = instr_req;
            instr_data    = rd(instr_addr);
            instr_valid_b = instr_req_b;
            instr_data_b  = rd(instr_addr_b);
        end
    end

    // Monitor: fetch-request rises and write-back windows are popped against the queues.
    initial begin
        int   cyc = 0, fetch_cyc = 0, rw_len = 0;
        logic prev_req = 1'b0;
        logic [1:0] prev_rw = 2'b00;
        wr_t  cur;
        forever begin
            @(negedge clk);
            cyc++;
            if (rst) begin
                prev_req = 1'b0;
                prev_rw  = 2'b00;
            end else begin
                if (instr_req && !prev_req) begin
                    fetch_cyc = cyc;
                    if (fetch_q.size() == 0) check("fetch_expected", fetch_q.size(), 1);
                    else check("fetch_addr", instr_addr, fetch_q.pop_front());
                end
                if (read_write != 2'b00 && prev_rw == 2'b00) begin
                    if (wr_q.size() == 0) begin
                        check("write_expected", wr_q.size(), 1);
                        cur = mk_wr(read_write, 5'd0, 3'd0, 16'd0, 3'd0, 3'd0, 3'd0, 3'd0, 1'b0, 0, 0, pc);
                    end else begin
                        cur = wr_q.pop_front();
                        check("wb_read_write", read_write, cur.rw);
                        check("wb_opcode", opcode, cur.op);
                        check("wb_control", control, cur.ctrl);
                        check("wb_imm_val", imm_val, cur.imm);
                        check("wb_write_addr_0", wa0, cur.wa0);
                        if (cur.chk_r) check("wb_r_fields", {wa1, ra0, ra1}, {cur.wa1, cur.ra0, cur.ra1});
                        check("wb_latency", cyc - fetch_cyc, cur.dly);
                    end
                    rw_len = 1;
                end else if (read_write != 2'b00) begin
                    rw_len++;
                end else if (prev_rw != 2'b00) begin
                    check("wb_length", rw_len, cur.len);
                    check("wb_pc_after", pc, cur.pc_after);
                end
                prev_req = instr_req;
                prev_rw  = read_write;
            end
        end
    end

    // Directed stimulus with hand-computed expectations.
    initial begin
        rst = 1'b1; run = 1'b0; run_b = 1'b0; alu_done = 1'b1; reg_done = 1'b1;
        repeat (3) @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        check("rst_pc", pc, 16'h0010);
        check("rst_instr_addr", instr_addr, 16'h0010);
        check("rst_instr_req", instr_req, 1'b0);
        check("rst_busy", busy, 1'b0);
        check("rst_halted", halted, 1'b0);
        check("rst_read_write", read_write, 2'b00);
        check("rst_decoded", {opcode, control, imm_val}, 24'h0);
        check("rst_addrs", {wa0, wa1, ra0, ra1}, 12'h0);
        repeat (3) @(negedge clk);
        check("idle_no_req", {instr_req, busy}, 2'b00);

        mem[16'h0010] = 32'hFB00_BEEF;
        mem[16'h0011] = 32'hE500_0000;
        mem[16'h0012] = r_type(5'b00001, 3'd1, 3'd2, 3'd4, 3'd6);
        mem[16'h0013] = r_type(5'b00011, 3'd7, 3'd6, 3'd1, 3'd2);
        mem[16'h0014] = 32'hE800_0040;
        mem[16'h0015] = 32'hF000_0000;
        mem[16'h0040] = 32'hF000_0000;
        fetch_q.push_back(16'h0010);
        fetch_q.push_back(16'h0011);
        fetch_q.push_back(16'h0012);
        fetch_q.push_back(16'h0013);
        fetch_q.push_back(16'h0014);
`ifdef DECODER_JUMP_EN
        fetch_q.push_back(16'h0040);
`else
        fetch_q.push_back(16'h0015);
`endif
        wr_q.push_back(mk_wr(2'b01, 5'b11111, 3'b011, 16'hBEEF, 3'd3, 3'd0, 3'd0, 3'd0, 1'b0, 1, 2, 16'h0011));
        wr_q.push_back(mk_wr(2'b01, 5'b11100, 3'b001, 16'h0000, 3'd5, 3'd0, 3'd0, 3'd0, 1'b0, 1, 2, 16'h0012));
        wr_q.push_back(mk_wr(2'b01, 5'b00001, 3'b000, 16'h0000, 3'd1, 3'd2, 3'd4, 3'd6, 1'b1, 1, 3, 16'h0013));
        wr_q.push_back(mk_wr(2'b11, 5'b00011, 3'b000, 16'h0000, 3'd7, 3'd6, 3'd1, 3'd2, 1'b1, 3, 8, 16'h0014));
        run = 1'b1;

        for (int i = 0; i < 60; i++) begin
            @(negedge clk);
            if (instr_req && instr_addr == 16'h0013) break;
        end
        check("reach_fetch_13", {instr_req, instr_addr}, {1'b1, 16'h0013});
        alu_done = 1'b0;
        reg_done = 1'b0;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            if (opcode == 5'b00011) break;
        end
        check("exec_opcode", opcode, 5'b00011);
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            check("exec_rw_idle", {busy, read_write}, 3'b100);
        end
        alu_done = 1'b1;
        @(negedge clk);
        alu_done = 1'b0;
        check("wb_dual_rw", read_write, 2'b11);
        @(negedge clk);
        check("wb_dual_hold", read_write, 2'b11);
        @(negedge clk);
        reg_done = 1'b1;

        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            if (halted) break;
        end
        check("halt_entered", {halted, busy, instr_req}, 3'b100);
        run = 1'b0;
        repeat (3) @(negedge clk);
        check("halt_run_low", halted, 1'b1);
        run = 1'b1;
        repeat (3) @(negedge clk);
        check("halt_run_high", {halted, instr_req}, 2'b10);

        mem[16'h0010] = r_type(5'b00011, 3'd2, 3'd3, 3'd4, 3'd5);
        fetch_q.push_back(16'h0010);
        alu_done = 1'b0;
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            if (opcode == 5'b00011) break;
        end
        check("rerun_exec_opcode", opcode, 5'b00011);
        @(negedge clk);
        rst = 1'b1;
        #1;
        check("midrst_read_write", read_write, 2'b00);
        check("midrst_pc", pc, 16'h0010);
        check("midrst_state", {busy, halted, instr_req}, 3'b000);
        check("midrst_opcode", opcode, 5'b00000);
        run = 1'b0;
        repeat (2) @(negedge clk);
        rst = 1'b0;

        mem[16'hFFFF] = r_type(5'b00010, 3'd1, 3'd2, 3'd3, 3'd4);
        alu_done = 1'b1;
        reg_done = 1'b1;
        @(negedge clk);
        check("wrap_rst_pc", pc_b, 16'hFFFF);
        run_b = 1'b1;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            if (read_write_b != 2'b00) break;
        end
        check("wrap_wb_rw", read_write_b, 2'b01);
        @(negedge clk);
        check("wrap_next_fetch", {instr_req_b, instr_addr_b, pc_b}, {1'b1, 16'h0000, 16'h0000});
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            if (halted_b) break;
        end
        check("wrap_halted", halted_b, 1'b1);
        run_b = 1'b0;

        repeat (2) @(negedge clk);
        check("fetch_q_drained", fetch_q.size(), 0);
        check("wr_q_drained", wr_q.size(), 0);
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

// File: doc/instr_decode_ctrl.md
# instr_decode_ctrl

Fetch/decode/sequencing controller that sits directly upstream of `processor`. It fetches 32-bit instruction words from instruction memory and decodes them into the `opcode`, `read_write`, `control`, `imm_val` and register-address fields that `processor` consumes. It then sequences each instruction through execute and write-back using the ALU and register-file done handshakes.

## Interface
- `PC_WIDTH`, 16, program counter / instruction address width
- `RESET_PC`, 0, PC value loaded on reset
- `clk`  in  1  system clock; all state updates on rising edge
- `rst`  in  1  asynchronous, active-high reset
- `run`  in  1  level; enables leaving IDLE/HALT
- `instr_addr`  out  PC_WIDTH  instruction memory address (= PC)
- `instr_req`  out  1  fetch request, held until `instr_valid`
- `instr_data`  in  32  instruction word, sampled when `instr_valid`=1
- `instr_valid`  in  1  instruction memory response strobe
- `alu_done`  in  1  ALU completion pulse
- `reg_done`  in  1  register-file write completion pulse
- `opcode`  out  5  to ALU
- `read_write`  out  2  bit0 = write port 0, bit1 = write port 1
- `control`  out  3  data_in_0 mux select
- `imm_val`  out  16  immediate
- `read_addr_0`, `read_addr_1`, `write_addr_0`, `write_addr_1`  out  3 each
- `pc`  out  PC_WIDTH  current PC
- `halted`  out  1  high in HALT state
- `busy`  out  1  high in any state other than IDLE/HALT

## Operation
- R-type fields: [31:27] op, [26:24] wa0, [23:21] wa1, [20:18] ra0, [17:15] ra1. I-type: [31:27] op, [26:24] wa0, [15:0] imm.
- Decode:
  - op 5'b11111 LOADI: control=011, rw=01, imm=instr[15:0].
  - op 5'b11100 IN: control=001, rw=01.
  - op 5'b11101 JMP: see Configuration.
  - op 5'b11110 HALT.
  - op 5'b00011/5'b00100 (two-result ops): control=000, rw=11.
  - All other ops: ALU, control=000, rw=01.
- States: IDLE, FETCH, DECODE, EXEC, WB, HALT.
  - IDLE: enter FETCH when `run`=1.
  - FETCH: `instr_req`=1. On `instr_valid`, latch the word and go to DECODE.
  - DECODE (1 cycle): register all decoded outputs. Next state is EXEC for ALU ops, WB for LOADI/IN, HALT for HALT.
  - EXEC: hold outputs. On `alu_done`, go to WB.
  - WB: drive `read_write` per decode, held until `reg_done`. Then set `read_write`=00, PC=PC+1, and go to FETCH, or to IDLE if `run`=0.
  - HALT: leave only on reset.
- PC increments modulo 2^PC_WIDTH; 0xFFFF wraps to 0x0000.
- Outputs other than `read_write` hold their last decoded value until the next DECODE.

## Timing
- Reset values: `pc`=RESET_PC, `instr_addr`=RESET_PC, `instr_req`=0, `opcode`=0, `read_write`=00, `control`=000, `imm_val`=0, all address outputs 0, `halted`=0, `busy`=0, state IDLE.
- Reset asserted mid-instruction aborts immediately. No write enable may remain asserted after `rst` rises.
- `instr_valid` in the same cycle `instr_req` first rises is accepted. `instr_valid` outside FETCH is ignored.
- `alu_done` outside EXEC and `reg_done` outside WB are ignored. Done pulses are never latched early.
- Minimum instruction latency with zero-wait memory and done responses (FETCH→DECODE→EXEC→WB):
  - ALU ops: 4 cycles.
  - LOADI/IN: 3 cycles.
- `read_write` is nonzero only in WB.

## Configuration
- `DECODER_JUMP_EN` defined:
  - JMP sets PC=instr[PC_WIDTH-1:0] in DECODE and goes straight to FETCH with `read_write`=00.
  - No EXEC or WB for JMP; latency 2 cycles.
- `DECODER_JUMP_EN` undefined:
  - op 5'b11101 is a NOP: PC=PC+1, DECODE→FETCH, no register write.

## Test plan
- Reset with RESET_PC=0x0010, `run`=0 -> `pc`=0x0010, `busy`=0, all outputs at reset values; no `instr_req`.
- LOADI wa0=3, imm=0xBEEF, zero-wait memory and `reg_done` -> `control`=011, `imm_val`=0xBEEF, `write_addr_0`=3, `read_write`=01 for exactly one cycle, `pc` increments by 1.
- Op 5'b00011, `alu_done` delayed 5 cycles -> stays in EXEC with `read_write`=00. On `alu_done`, `read_write`=11 until `reg_done`.
- JMP imm=0x0040 with the macro defined -> next `instr_addr`=0x0040, no register write. Without the macro -> next `instr_addr`=PC+1.
- PC=0xFFFF executing an ALU op -> next fetch address is 0x0000.
- HALT, then `rst` pulsed mid-EXEC of a following run -> `halted`=1 and stays high regardless of `run`. After reset, `read_write`=00 and `pc`=RESET_PC.
